// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Holds the fetch PC and picks the next PC from four sources: sequential,
// j/jal, jr, or a taken beq. It drives the instruction-memory address and
// captures the fetched word into the IF/ID pipeline register. Load-use
// stalls and control-hazard flushes are handled here.
//
// Optional build macro: IF_PERF_CNT_EN
//   Defined   : stall_count and flush_count are live 32-bit wrapping counters.
//   Undefined : no counter registers exist, and both outputs are tied to 0.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   stall         load-use stall; holds the PC and IF/ID
//   flush         inserts a bubble into IF/ID (the PC is not affected)
//   PCSrc         00 sequential, 01 j/jal, 10 jr, 11 treated as sequential
//   jump_index    IR[25:0] of the instruction in decode
//   jr_target     forwarded rs value, used by jr
//   branch_taken  beq resolved as taken in execute
//   branch_target beq target computed in execute
//   imem_addr     instruction-memory address (equals PC, combinational)
//   imem_rdata    instruction word at imem_addr, returned in the same cycle
//   PC            current fetch PC
//   IR, PC_plus4  IF/ID instruction, and the PC+4 that belongs to it
//   id_valid      1 when IF/ID holds a real instruction, 0 for a bubble
//   stall_count   number of stalled edges that were not overridden by a branch
//   flush_count   number of bubbles inserted
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  PCSrc,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] IR,
  output logic [31:0] PC_plus4,
  output logic        id_valid,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  logic [31:0] seq_pc;
  logic [31:0] jump_pc;
  logic [31:0] jr_pc;
  logic [31:0] next_pc;
  logic        redirect;
  logic        bubble;

  assign imem_addr = PC;
  assign seq_pc    = PC + 32'd4;  // wraps modulo 2^32
  // The jump region comes from the PC+4 of the instruction in decode,
  // not from the current fetch PC.
  assign jump_pc   = {PC_plus4[31:28], jump_index, 2'b00};
  assign jr_pc     = jr_target & ~32'h3;
  assign redirect  = (PCSrc == 2'b01) || (PCSrc == 2'b10);
  // A decode-stage redirect only counts when decode itself is not stalled.
  assign bubble    = branch_taken || flush || (!stall && redirect);

  // NOTE: always_comb assigns a default first, so every path drives
  //       next_pc and no latch can be inferred.
  always_comb begin
    next_pc = seq_pc;
    // A taken branch wins over stall, because the execute instruction is older.
    if (branch_taken)          next_pc = branch_target;
    else if (stall)            next_pc = PC;
    else if (PCSrc == 2'b01)   next_pc = jump_pc;
    else if (PCSrc == 2'b10)   next_pc = jr_pc;
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  //       samples values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC       <= RESET_PC;
      IR       <= NOP_WORD;
      PC_plus4 <= 32'd0;
      id_valid <= 1'b0;
    end else begin
      PC <= next_pc;
      if (bubble) begin
        IR       <= NOP_WORD;
        PC_plus4 <= 32'd0;
        id_valid <= 1'b0;
      end else if (!stall) begin
        IR       <= imem_rdata;
        PC_plus4 <= seq_pc;
        id_valid <= 1'b1;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= 32'd0;
      flush_count <= 32'd0;
    end else begin
      if (stall && !branch_taken) stall_count <= stall_count + 32'd1;
      if (bubble)                 flush_count <= flush_count + 32'd1;
    end
  end
`else
  assign stall_count = 32'd0;
  assign flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
// The bench runs directed scenarios first, then randomized control inputs.
// Every result is compared against a cycle-level reference model.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, branch_taken;
  logic [1:0]  PCSrc;
  logic [25:0] jump_index;
  logic [31:0] jr_target, branch_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] PC, IR, PC_plus4, stall_count, flush_count;
  logic        id_valid;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  logic [31:0] m_pc, m_ir, m_pc4, m_scnt, m_fcnt;
  logic        m_valid;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .PCSrc(PCSrc),
    .jump_index(jump_index), .jr_target(jr_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .PC(PC), .IR(IR),
    .PC_plus4(PC_plus4), .id_valid(id_valid),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // Instruction memory: word 0 is fixed, and every other address holds a hashed word.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  always_comb imem_rdata = imem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".PC"},        PC,        m_pc);
    check({tag, ".imem_addr"}, imem_addr, m_pc);
    check({tag, ".IR"},        IR,        m_ir);
    check({tag, ".PC_plus4"},  PC_plus4,  m_pc4);
    check({tag, ".id_valid"},  {31'd0, id_valid}, {31'd0, m_valid});
    check({tag, ".stall_cnt"}, stall_count, m_scnt);
    check({tag, ".flush_cnt"}, flush_count, m_fcnt);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ir = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
    m_scnt = 32'h0; m_fcnt = 32'h0;
  endtask

  // Set the inputs, advance one edge, update the model, and compare 1 ns later.
  task automatic step(input string tag, input logic s, input logic f, input logic [1:0] src,
                      input logic [25:0] ji, input logic [31:0] jr,
                      input logic bt, input logic [31:0] btgt);
    logic [31:0] npc;
    logic        bub;
    stall = s; flush = f; PCSrc = src; jump_index = ji;
    jr_target = jr; branch_taken = bt; branch_target = btgt;
    if (bt)              npc = btgt;
    else if (s)          npc = m_pc;
    else if (src == 2'd1) npc = (m_pc4 & 32'hF000_0000) | ({6'd0, ji} << 2);
    else if (src == 2'd2) npc = jr & 32'hFFFF_FFFC;
    else                 npc = m_pc + 32'd4;
    bub = bt || f || (!s && (src == 2'd1 || src == 2'd2));
    @(posedge clk);
`ifdef IF_PERF_CNT_EN
    if (s && !bt) m_scnt = m_scnt + 1;
    if (bub)      m_fcnt = m_fcnt + 1;
`endif
    if (bub) begin
      m_ir = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (!s) begin
      m_ir = imem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
    end
    m_pc = npc;
    #1;
    check_all(tag);
  endtask

  task automatic seq(input string tag);
    step(tag, 1'b0, 1'b0, 2'd0, 26'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    stall = 0; flush = 0; PCSrc = 0; jump_index = 0; jr_target = 0;
    branch_taken = 0; branch_target = 0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Directed: the first fetch, then a sequential run.
    seq("first");
    check("first.IR_word0", IR, 32'h2008_0005);
    seq("seq8"); seq("seqC"); seq("seq10");

    // Directed: reset, then build PC_plus4=8 and issue a j with index 0x10.
    reset = 1'b1; #1; model_reset(); @(negedge clk); reset = 1'b0;
    seq("pre_j0"); seq("pre_j1");
    step("jump", 1'b0, 1'b0, 2'd1, 26'h10, 32'd0, 1'b0, 32'd0);
    check("jump.PC40", PC, 32'h40);
    seq("after_jump");

    // Directed: a jr held under stall for two cycles, then released.
    step("jr_stall0", 1'b1, 1'b0, 2'd2, 26'd0, 32'h100, 1'b0, 32'd0);
    step("jr_stall1", 1'b1, 1'b0, 2'd2, 26'd0, 32'h100, 1'b0, 32'd0);
    step("jr_go",     1'b0, 1'b0, 2'd2, 26'd0, 32'h100, 1'b0, 32'd0);
    check("jr_go.PC100", PC, 32'h100);
    seq("after_jr");

    // Directed: a taken branch together with a stall.
    step("br_stall", 1'b1, 1'b0, 2'd0, 26'd0, 32'd0, 1'b1, 32'h24);
    // Directed: a flush together with a stall (PC held, IF/ID bubbled).
    step("flush_stall", 1'b1, 1'b1, 2'd0, 26'd0, 32'd0, 1'b0, 32'd0);
    // Directed: PCSrc=11 behaves as sequential.
    step("src11", 1'b0, 1'b0, 2'd3, 26'h3FFFFFF, 32'hFF, 1'b0, 32'd0);

    // Directed: wrap from FFFFFFFC, reached through a misaligned jr target.
    step("jr_mis", 1'b0, 1'b0, 2'd2, 26'd0, 32'hFFFF_FFFF, 1'b0, 32'd0);
    seq("wrap");
    check("wrap.PC0", PC, 32'h0);

    // Randomized control traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(3) == 0), ($urandom_range(9) == 0),
           2'($urandom_range(3)), 26'($urandom), $urandom,
           ($urandom_range(6) == 0), $urandom);
    end

    // Reset asserted mid-cycle must take effect without a clock edge.
    @(posedge clk); #3;
    reset = 1'b1; #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk); reset = 1'b0;
    seq("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Holds the PC, selects the next PC (sequential, j/jal, jr, taken beq), drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register.
- Supports load-use stalls and control-hazard flushes.
- Outputs IR and PC_plus4 feed the decode stage directly.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_WORD, 32'h00000000, bubble instruction written into IR on flush (sll $0,$0,0)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  load-use stall from hazard unit: hold PC and IF/ID
flush  input  1  external flush request: bubble into IF/ID
PCSrc  input  2  from decode: 00 sequential, 01 j/jal, 10 jr, 11 treated as 00
jump_index  input  26  IR[25:0] of the instruction in decode
jr_target  input  32  forwarded rs value for jr
branch_taken  input  1  from execute: beq resolved taken
branch_target  input  32  from execute: PC+4 + (sext(imm)<<2)
imem_addr  output  32  combinational, equals PC
imem_rdata  input  32  instruction word at imem_addr, same cycle
PC  output  32  current fetch PC
IR  output  32  IF/ID instruction
PC_plus4  output  32  IF/ID PC+4 of IR
id_valid  output  1  IF/ID holds a real instruction (0 = bubble)
stall_count  output  32  see Optional Feature
flush_count  output  32  see Optional Feature

Behaviour:
- Reset, asynchronous and active-high: PC=RESET_PC, IR=NOP_WORD, PC_plus4=0, id_valid=0, counters=0. Reset asserted mid-operation discards all in-flight state immediately, with no clock edge needed.
- imem_addr = PC, combinational. Fetch latency is one cycle: the word at PC appears on IR after the next rising edge.
- seq = PC + 4, computed modulo 2^32. 32'hFFFFFFFC wraps to 0 silently.
- jtarget = {PC_plus4[31:28], jump_index, 2'b00}, using the IF/ID PC_plus4, i.e. the decode instruction's PC+4.
- jr next PC = {jr_target[31:2], 2'b00}. Misaligned low bits are dropped.
- Next-PC priority, evaluated every edge:
  1. branch_taken: PC<=branch_target. Overrides stall because the execute-stage instruction is older.
  2. stall: PC held. PCSrc is ignored because the decode instruction is itself stalled.
  3. PCSrc=01: PC<=jtarget.
  4. PCSrc=10: PC<=jr next PC (as above).
  5. Otherwise: PC<=seq.
- IF/ID register update, same priority order:
  - bubble when branch_taken=1, or flush=1, or (stall=0 and PCSrc is 01 or 10). Bubble means IR<=NOP_WORD, PC_plus4<=0, id_valid<=0.
  - else, stall=1: IR, PC_plus4 and id_valid held.
  - else: IR<=imem_rdata, PC_plus4<=seq, id_valid<=1.
- flush does not alter the PC; the PC follows the priority list above.
- stall and flush together: IF/ID is bubbled and the PC is held, unless branch_taken is also asserted.
- No state machine beyond PC, IF/ID and the counters. Each redirect costs exactly one bubble (j/jal/jr) or one bubble from this stage (beq).

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - stall_count increments by 1 on each edge where stall=1 and branch_taken=0.
  - flush_count increments by 1 on each edge where a bubble is inserted.
  - Both are 32-bit, wrap from FFFFFFFF to 0, and are cleared by reset.
- Undefined: no counter registers exist; stall_count and flush_count are tied to 0.

Test Plan:
- Release reset with RESET_PC=0 and imem word[0]=32'h20080005 -> after edge 1: IR=20080005, PC_plus4=4, id_valid=1, PC=4.
- Sequential run through 4 words -> PC goes 4,8,C,10 and IR tracks each word one cycle behind.
- PCSrc=01, jump_index=26'h0000010, IF/ID PC_plus4=8 -> PC=00000040, IR=NOP_WORD, id_valid=0; next edge fetches the word at 0x40.
- stall=1 for 2 cycles while PCSrc=10 and jr_target=0x100 -> PC and IR unchanged both cycles; after release, PC=0x100 and one bubble is inserted.
- branch_taken=1 with branch_target=0x24 and stall=1 in the same cycle -> PC=24, id_valid=0; with IF_PERF_CNT_EN, flush_count+1 and stall_count unchanged.
- PC=FFFFFFFC sequential -> PC=0 and PC_plus4=0. Assert reset mid-cycle -> PC=RESET_PC and id_valid=0 before the next edge.
